// File: rtl/meter_pkg.sv
// Shared defaults, output FSM encoding and the saturating magnitude helper
// used by the multichannel peak meter.
package meter_pkg;

    localparam int unsigned DEF_NUM_CH   = 2;
    localparam int unsigned DEF_SAMPLE_W = 24;
    localparam int unsigned DEF_SIZE_W   = 10;
    localparam int unsigned DEF_HOLD_W   = 8;

    // Working width for the magnitude helper; callers sign-extend into it.
    localparam int unsigned MAG_CALC_W = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // |x| clamped to 2^(sample_w-1)-1 so the most negative code stays in range.
    function automatic logic [MAG_CALC_W-1:0] sat_mag(
        input logic signed [MAG_CALC_W-1:0] x,
        input int unsigned                  sample_w
    );
        logic [MAG_CALC_W-1:0] lim;
        logic [MAG_CALC_W-1:0] mag;
        lim = (MAG_CALC_W'(1) << (sample_w - 1)) - MAG_CALC_W'(1);
        mag = x[MAG_CALC_W-1] ? MAG_CALC_W'(-x) : MAG_CALC_W'(x);
        return (mag > lim) ? lim : mag;
    endfunction

endpackage

// File: rtl/peak_meter_channel.sv
// One audio channel: saturating magnitude, running block maximum and
// peak-hold with delayed linear decay.
module peak_meter_channel
    import meter_pkg::*;
#(
    parameter int unsigned SAMPLE_W = DEF_SAMPLE_W,
    parameter int unsigned HOLD_W   = DEF_HOLD_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                vin,
    input  logic                block_end,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [HOLD_W-1:0]   hold_blocks,
    input  logic [SAMPLE_W-2:0] decay_step,
    output logic [SAMPLE_W-2:0] peak,
    output logic [SAMPLE_W-2:0] hold_next
);

    localparam int unsigned MAG_W = SAMPLE_W - 1;

    logic [MAG_W-1:0]  mag;
    logic [MAG_W-1:0]  acc;
    logic [MAG_W-1:0]  hold;
    logic [MAG_W-1:0]  decayed;
    logic [HOLD_W-1:0] cnt;
    logic [HOLD_W-1:0] cnt_next;

    always_comb begin
        mag       = MAG_W'(sat_mag(MAG_CALC_W'(signed'(sample)), SAMPLE_W));
        peak      = (mag > acc) ? mag : acc;
        decayed   = (hold > decay_step) ? (hold - decay_step) : '0;
        hold_next = hold;
        cnt_next  = cnt;
        if (peak >= hold) begin
            hold_next = peak;
            cnt_next  = hold_blocks;
        end else if (cnt != '0) begin
            cnt_next = cnt - HOLD_W'(1);
        end else begin
            hold_next = (decayed > peak) ? decayed : peak;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            hold <= '0;
            cnt  <= '0;
        end else if (vin) begin
            if (block_end) begin
                acc  <= '0;
                hold <= hold_next;
                cnt  <= cnt_next;
            end else begin
                acc <= peak;
            end
        end
    end

endmodule

// File: rtl/multichannel_peak_meter.sv
// Multichannel block peak meter: shared block counter, per-channel meters and
// a snapshot FSM that streams one result per channel over a valid/ready port.
module multichannel_peak_meter
    import meter_pkg::*;
#(
    parameter int unsigned NUM_CH   = DEF_NUM_CH,
    parameter int unsigned SAMPLE_W = DEF_SAMPLE_W,
    parameter int unsigned SIZE_W   = DEF_SIZE_W,
    parameter int unsigned HOLD_W   = DEF_HOLD_W
) (
    input  logic                       mclk,
    input  logic                       mclk_rst,
    input  logic [SIZE_W-1:0]          block_size,
    input  logic [HOLD_W-1:0]          hold_blocks,
    input  logic [SAMPLE_W-2:0]        decay_step,
    input  logic                       vin,
    input  logic [NUM_CH*SAMPLE_W-1:0] din,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2:0]                 out_chan,
    output logic [SAMPLE_W-2:0]        out_peak,
    output logic [SAMPLE_W-2:0]        out_hold,
    output logic                       out_last,
    output logic                       overrun,
    input  logic                       overrun_clear
);

    localparam int unsigned MAG_W   = SAMPLE_W - 1;
    localparam logic [2:0]  LAST_CH = 3'(NUM_CH - 1);

    logic [SIZE_W-1:0] cnt;
    logic [SIZE_W-1:0] size_lat;
    logic [SIZE_W-1:0] eff_size;
    logic              block_end;

    // A fresh block takes the live block_size; later samples use the latched copy.
    always_comb begin
        if (cnt == '0) begin
            eff_size = (block_size == '0) ? SIZE_W'(1) : block_size;
        end else begin
            eff_size = size_lat;
        end
        block_end = vin && (((SIZE_W+1)'(cnt) + (SIZE_W+1)'(1)) == (SIZE_W+1)'(eff_size));
    end

    always_ff @(posedge mclk) begin
        if (mclk_rst) begin
            cnt      <= '0;
            size_lat <= '0;
        end else if (vin) begin
            if (cnt == '0) begin
                size_lat <= eff_size;
            end
            cnt <= block_end ? '0 : (cnt + SIZE_W'(1));
        end
    end

    logic [MAG_W-1:0] ch_peak [NUM_CH];
    logic [MAG_W-1:0] ch_hold [NUM_CH];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        peak_meter_channel #(
            .SAMPLE_W(SAMPLE_W),
            .HOLD_W  (HOLD_W)
        ) u_ch (
            .clk        (mclk),
            .rst        (mclk_rst),
            .vin        (vin),
            .block_end  (block_end),
            .sample     (din[k*SAMPLE_W +: SAMPLE_W]),
            .hold_blocks(hold_blocks),
            .decay_step (decay_step),
            .peak       (ch_peak[k]),
            .hold_next  (ch_hold[k])
        );
    end

    state_t           state;
    state_t           state_next;
    logic [2:0]       chan;
    logic [2:0]       chan_next;
    logic             load;
    logic             ovr_set;
    logic             xfer;
    logic             at_last;
    logic [MAG_W-1:0] snap_peak [NUM_CH];
    logic [MAG_W-1:0] snap_hold [NUM_CH];

    always_comb begin
        at_last    = (chan == LAST_CH);
        xfer       = (state == ST_SEND) && out_ready;
        state_next = state;
        chan_next  = chan;
        load       = 1'b0;
        ovr_set    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (block_end) begin
                    state_next = ST_SEND;
                    chan_next  = '0;
                    load       = 1'b1;
                end
            end
            ST_SEND: begin
                // Final transfer frees the snapshot slot, so a coincident block end is accepted.
                if (xfer && at_last) begin
                    chan_next = '0;
                    if (block_end) begin
                        load = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    if (xfer) begin
                        chan_next = chan + 3'd1;
                    end
                    if (block_end) begin
                        ovr_set = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (mclk_rst) begin
            state   <= ST_IDLE;
            chan    <= '0;
            overrun <= 1'b0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                snap_peak[k] <= '0;
                snap_hold[k] <= '0;
            end
        end else begin
            state <= state_next;
            chan  <= chan_next;
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (overrun_clear) begin
                overrun <= 1'b0;
            end
            if (load) begin
                for (int unsigned k = 0; k < NUM_CH; k++) begin
                    snap_peak[k] <= ch_peak[k];
                    snap_hold[k] <= ch_hold[k];
                end
            end
        end
    end

    always_comb begin
        out_valid = (state == ST_SEND);
        out_chan  = chan;
        out_last  = (state == ST_SEND) && at_last;
        out_peak  = '0;
        out_hold  = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (chan == 3'(k)) begin
                out_peak = snap_peak[k];
                out_hold = snap_hold[k];
            end
        end
    end

endmodule

// File: tb/tb_multichannel_peak_meter.sv
// Bench for multichannel_peak_meter: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level reference model.
module tb_multichannel_peak_meter;

    localparam int unsigned NUM_CH   = 2;
    localparam int unsigned SAMPLE_W = 24;
    localparam int unsigned SIZE_W   = 10;
    localparam int unsigned HOLD_W   = 8;
    localparam longint      MAG_MAX  = (longint'(1) << (SAMPLE_W - 1)) - 1;

    logic                       mclk = 1'b0;
    logic                       mclk_rst;
    logic [SIZE_W-1:0]          block_size;
    logic [HOLD_W-1:0]          hold_blocks;
    logic [SAMPLE_W-2:0]        decay_step;
    logic                       vin;
    logic [NUM_CH*SAMPLE_W-1:0] din;
    logic                       out_valid;
    logic                       out_ready;
    logic [2:0]                 out_chan;
    logic [SAMPLE_W-2:0]        out_peak;
    logic [SAMPLE_W-2:0]        out_hold;
    logic                       out_last;
    logic                       overrun;
    logic                       overrun_clear;

    always #5 mclk = ~mclk;

    multichannel_peak_meter #(
        .NUM_CH  (NUM_CH),
        .SAMPLE_W(SAMPLE_W),
        .SIZE_W  (SIZE_W),
        .HOLD_W  (HOLD_W)
    ) dut (
        .mclk         (mclk),
        .mclk_rst     (mclk_rst),
        .block_size   (block_size),
        .hold_blocks  (hold_blocks),
        .decay_step   (decay_step),
        .vin          (vin),
        .din          (din),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_chan     (out_chan),
        .out_peak     (out_peak),
        .out_hold     (out_hold),
        .out_last     (out_last),
        .overrun      (overrun),
        .overrun_clear(overrun_clear)
    );

    int checks;
    int errors;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: block contents kept as lists of magnitudes.
    longint m_mags [NUM_CH][$];
    longint m_hold [NUM_CH];
    longint m_hcnt [NUM_CH];
    longint m_snap_peak [NUM_CH];
    longint m_snap_hold [NUM_CH];
    int     m_cnt;
    int     m_lat;
    bit     m_valid;
    int     m_idx;
    bit     m_ovr;

    function automatic longint ref_mag(input logic [SAMPLE_W-1:0] s);
        longint v;
        v = longint'(s);
        if (s[SAMPLE_W-1]) v = v - (longint'(1) << SAMPLE_W);
        if (v < 0) v = -v;
        if (v > MAG_MAX) v = MAG_MAX;
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_mags[k].delete();
            m_hold[k]      = 0;
            m_hcnt[k]      = 0;
            m_snap_peak[k] = 0;
            m_snap_hold[k] = 0;
        end
        m_cnt   = 0;
        m_lat   = 1;
        m_valid = 0;
        m_idx   = 0;
        m_ovr   = 0;
    endtask

    task automatic model_edge();
        bit     ended;
        bit     set;
        longint pk [NUM_CH];
        longint d;
        if (mclk_rst) begin
            model_reset();
            return;
        end
        ended = 0;
        set   = 0;
        if (vin) begin
            if (m_cnt == 0) m_lat = (block_size == 0) ? 1 : int'(block_size);
            for (int k = 0; k < NUM_CH; k++) m_mags[k].push_back(ref_mag(din[k*SAMPLE_W +: SAMPLE_W]));
            m_cnt++;
            if (m_cnt == m_lat) begin
                ended = 1;
                m_cnt = 0;
                for (int k = 0; k < NUM_CH; k++) begin
                    pk[k] = 0;
                    foreach (m_mags[k][i]) if (m_mags[k][i] > pk[k]) pk[k] = m_mags[k][i];
                    m_mags[k].delete();
                    if (pk[k] >= m_hold[k]) begin
                        m_hold[k] = pk[k];
                        m_hcnt[k] = longint'(hold_blocks);
                    end else if (m_hcnt[k] != 0) begin
                        m_hcnt[k]--;
                    end else begin
                        d = m_hold[k] - longint'(decay_step);
                        if (d < 0) d = 0;
                        m_hold[k] = (d > pk[k]) ? d : pk[k];
                    end
                end
            end
        end
        if (!m_valid || (out_ready && m_idx == NUM_CH - 1)) begin
            if (ended) begin
                m_valid = 1;
                m_idx   = 0;
                for (int k = 0; k < NUM_CH; k++) begin
                    m_snap_peak[k] = pk[k];
                    m_snap_hold[k] = m_hold[k];
                end
            end else begin
                m_valid = 0;
                m_idx   = 0;
            end
        end else begin
            if (ended) set = 1;
            if (out_ready) m_idx++;
        end
        if (set) m_ovr = 1;
        else if (overrun_clear) m_ovr = 0;
    endtask

    task automatic check_outputs();
        check("valid", out_valid, m_valid);
        check("overrun", overrun, m_ovr);
        if (m_valid) begin
            check("chan", out_chan, m_idx);
            check("peak", out_peak, m_snap_peak[m_idx]);
            check("hold", out_hold, m_snap_hold[m_idx]);
            check("last", out_last, (m_idx == NUM_CH - 1) ? 1 : 0);
        end
    endtask

    // One clock: apply inputs, compare mid-cycle, advance model with the edge.
    task automatic step(input bit v, input logic [NUM_CH*SAMPLE_W-1:0] d);
        vin = v;
        din = d;
        @(negedge mclk);
        check_outputs();
        model_edge();
        @(posedge mclk);
        #1;
    endtask

    function automatic logic [NUM_CH*SAMPLE_W-1:0] pack2(input int a, input int b);
        logic [SAMPLE_W-1:0] x;
        logic [SAMPLE_W-1:0] y;
        x = a[SAMPLE_W-1:0];
        y = b[SAMPLE_W-1:0];
        return {y, x};
    endfunction

    task automatic do_reset();
        mclk_rst = 1'b1;
        step(0, '0);
        mclk_rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0);
    endtask

    initial begin
        longint exp_h [5];
        int     pks [5];
        logic [NUM_CH*SAMPLE_W-1:0] d;
        logic [SAMPLE_W-1:0]        s;
        int                         r;

        checks = 0;
        errors = 0;
        model_reset();
        mclk_rst      = 1'b1;
        vin           = 1'b0;
        din           = '0;
        block_size    = 10'd4;
        hold_blocks   = '0;
        decay_step    = '0;
        out_ready     = 1'b0;
        overrun_clear = 1'b0;
        @(posedge mclk);
        #1;
        step(0, '0);
        mclk_rst = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_chan", out_chan, 0);
        check("rst_peak", out_peak, 0);
        check("rst_hold", out_hold, 0);
        check("rst_last", out_last, 0);
        check("rst_overrun", overrun, 0);

        // Block of 4 with a most-negative code on ch1.
        block_size = 10'd4;
        out_ready  = 1'b0;
        step(1, pack2(5, 32'h800000));
        step(1, pack2(-9, 32'h800000));
        step(1, pack2(3, 32'h800000));
        check("t1_early", out_valid, 0);
        step(1, pack2(2, 32'h800000));
        check("t1_valid", out_valid, 1);
        check("t1_peak0", out_peak, 9);
        step(0, '0);
        out_ready = 1'b1;
        step(0, '0);
        check("t1_peak1", out_peak, 32'h7FFFFF);
        check("t1_last", out_last, 1);
        idle(2);

        // Hold for two blocks, then linear decay.
        do_reset();
        hold_blocks = 8'd2;
        decay_step  = 23'd100;
        block_size  = 10'd1;
        out_ready   = 1'b1;
        exp_h = '{1000, 1000, 1000, 900, 800};
        pks   = '{1000, 0, 0, 0, 0};
        for (int i = 0; i < 5; i++) begin
            step(1, pack2(pks[i], 0));
            check($sformatf("t2_hold%0d", i), out_hold, exp_h[i]);
            idle(2);
        end

        // Stalled consumer: later blocks are dropped but still tracked by hold.
        do_reset();
        hold_blocks = '0;
        decay_step  = '0;
        block_size  = 10'd1;
        out_ready   = 1'b0;
        for (int i = 1; i <= 10; i++) step(1, pack2(10 * i, 0));
        check("t3_overrun", overrun, 1);
        check("t3_chan", out_chan, 0);
        check("t3_first", out_peak, 10);
        out_ready = 1'b1;
        idle(3);
        step(1, pack2(0, 0));
        check("t3_hold", out_hold, 100);
        idle(2);
        overrun_clear = 1'b1;
        step(0, '0);
        overrun_clear = 1'b0;
        check("t3_clear", overrun, 0);

        // Block end coincident with the final-channel transfer.
        do_reset();
        block_size = 10'd1;
        out_ready  = 1'b1;
        step(1, pack2(7, 8));
        step(0, '0);
        step(1, pack2(3, 4));
        check("t4_valid", out_valid, 1);
        check("t4_chan", out_chan, 0);
        check("t4_overrun", overrun, 0);
        check("t4_peak", out_peak, 3);
        idle(3);

        // Block size change mid-block, then size 0.
        do_reset();
        block_size = 10'd4;
        out_ready  = 1'b1;
        step(1, pack2(1, 0));
        step(1, pack2(2, 0));
        block_size = 10'd2;
        step(1, pack2(3, 0));
        check("t5_mid", out_valid, 0);
        step(1, pack2(4, 0));
        check("t5_end4", out_valid, 1);
        check("t5_pk4", out_peak, 4);
        idle(2);
        step(1, pack2(5, 0));
        check("t5_mid2", out_valid, 0);
        step(1, pack2(6, 0));
        check("t5_end2", out_valid, 1);
        check("t5_pk2", out_peak, 6);
        idle(2);
        block_size = '0;
        step(1, pack2(-11, 0));
        check("t5_zero_a", out_valid, 1);
        check("t5_zero_pk", out_peak, 11);
        idle(2);
        step(1, pack2(12, 0));
        check("t5_zero_b", out_valid, 1);
        idle(2);

        // Reset while sending and mid-block.
        do_reset();
        block_size = 10'd2;
        out_ready  = 1'b0;
        step(1, pack2(100, 0));
        step(1, pack2(200, 0));
        check("t6_send", out_valid, 1);
        step(1, pack2(5000, 0));
        mclk_rst = 1'b1;
        step(0, '0);
        mclk_rst = 1'b0;
        check("t6_valid", out_valid, 0);
        out_ready = 1'b1;
        step(1, pack2(7, 0));
        step(1, pack2(3, 0));
        check("t6_after", out_valid, 1);
        check("t6_peak", out_peak, 7);
        idle(2);

        // Randomized traffic.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            out_ready     = ($urandom_range(0, 9) < 7);
            overrun_clear = ($urandom_range(0, 19) == 0);
            mclk_rst      = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 49) == 0) block_size  = SIZE_W'($urandom_range(0, 5));
            if ($urandom_range(0, 49) == 0) hold_blocks = HOLD_W'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) decay_step  = (SAMPLE_W-1)'($urandom_range(0, 2000));
            for (int k = 0; k < NUM_CH; k++) begin
                case ($urandom_range(0, 3))
                    0: s = 24'h800000;
                    1: begin
                        r = int'($urandom_range(0, 6000)) - 3000;
                        s = r[SAMPLE_W-1:0];
                    end
                    2: s = SAMPLE_W'($urandom);
                    default: s = '0;
                endcase
                d[k*SAMPLE_W +: SAMPLE_W] = s;
            end
            step(bit'($urandom_range(0, 1)), d);
        end
        mclk_rst      = 1'b0;
        overrun_clear = 1'b0;
        out_ready     = 1'b1;
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multichannel_peak_meter.md
MULTICHANNEL_PEAK_METER -- requirements
Module: multichannel_peak_meter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of audio channels (1..8).
REQ-002 SHALL have parameter SAMPLE_W, default 24, two's-complement sample width.
REQ-003 SHALL have parameter SIZE_W, default 10, block-size field width.
REQ-004 SHALL have parameter HOLD_W, default 8, hold-count field width.
REQ-005 SHALL have port mclk  in  1  sole clock; one clock; reset is synchronous and active-high.
REQ-006 SHALL have port mclk_rst  in  1  synchronous active-high reset.
REQ-007 SHALL have port block_size  in  SIZE_W  samples per block; 0 treated as 1.
REQ-008 SHALL have port hold_blocks  in  HOLD_W  blocks a new peak is held before decay.
REQ-009 SHALL have port decay_step  in  SAMPLE_W-1  hold decrement per block after hold expires.
REQ-010 SHALL have port vin  in  1  sample strobe; all channels are valid together.
REQ-011 SHALL have port din  in  NUM_CH*SAMPLE_W  samples; channel k is at bits [k*SAMPLE_W +: SAMPLE_W].
REQ-012 SHALL have port out_valid / out_ready  out / in  1  per-channel result handshake.
REQ-013 SHALL have port out_chan  out  3  channel index of the current result.
REQ-014 SHALL have port out_peak / out_hold  out  SAMPLE_W-1  block peak and held peak magnitudes.
REQ-015 SHALL have port out_last  out  1  high with the result for channel NUM_CH-1.
REQ-016 SHALL have port overrun / overrun_clear  out / in  1  sticky dropped-block flag and its clear.

Function
REQ-017 SHALL compute the magnitude as |x|; the most negative code SHALL saturate to 2^(SAMPLE_W-1)-1.
REQ-018 SHALL keep a per-channel running maximum of the magnitude over vin samples only; cycles with vin low SHALL leave all state unchanged.
REQ-019 SHALL latch block_size at block start; a change mid-block SHALL take effect from the next block.
REQ-020 SHALL end a block on the vin that completes the latched count; the block peak SHALL be max(accumulator, current magnitude), and the accumulator SHALL restart at 0 on the next sample.
REQ-021 SHALL update hold on every block end as follows:
  - if peak >= hold: hold <= peak and counter <= hold_blocks;
  - else if counter != 0: counter decrements;
  - else: hold <= max(hold - decay_step, peak), saturating with no underflow.
REQ-022 SHALL perform the hold update even when the snapshot is dropped.
REQ-023 SHALL run a two-state FSM:
  - IDLE -> SEND when a block ends: snapshot peak and updated hold of all channels, out_chan = 0.
  - SEND -> SEND on out_valid&&out_ready with !out_last: out_chan increments.
  - SEND -> IDLE on transfer with out_last and no simultaneous block end.
REQ-024 SHALL assert out_valid on the first clock edge after the vin that ends a block (latency 1).
REQ-025 SHALL hold out_chan, out_peak, out_hold and out_last stable while out_valid && !out_ready.
REQ-026 SHALL handle a block end while in SEND with no final transfer in the same cycle as follows: drop the new snapshot, continue the current one, and set overrun.
REQ-027 SHALL handle a block end in the same cycle as a final-channel transfer as follows: load the new snapshot, stay in SEND with out_chan = 0, and leave overrun unchanged.
REQ-028 SHALL clear overrun on overrun_clear; if a set event occurs in the same cycle, set SHALL win.
REQ-029 SHALL use unsigned magnitude arithmetic of width SAMPLE_W-1; no intermediate result SHALL wrap.

Reset
REQ-030 SHALL on mclk_rst force: out_valid=0, out_chan=0, out_peak=0, out_hold=0, out_last=0, overrun=0, FSM=IDLE, sample count=0, all accumulators/holds/counters=0.
REQ-031 SHALL make reset mid-block or mid-SEND discard all pending data, with no output on the following cycle.

Structure
REQ-032 SHALL place the default parameter values, the FSM state encoding and the magnitude-saturation function in shared package meter_pkg.
REQ-033 SHALL implement per-channel magnitude, accumulation and hold/decay in sub-module peak_meter_channel, instantiated NUM_CH times; the block counter and output FSM SHALL live in the top.

Verification
REQ-034 SHALL cover: NUM_CH=2, block_size=4, ch0 samples 5,-9,3,2, ch1 all 0x800000 -> ch0 peak 9, ch1 peak 0x7FFFFF, out_valid one cycle after the 4th vin.
REQ-035 SHALL cover: hold_blocks=2, decay_step=100, block peaks 1000,0,0,0,0 -> out_hold 1000,1000,1000,900,800.
REQ-036 SHALL cover: out_ready held low for 10 blocks of size 1 -> overrun=1, first snapshot still delivered intact, hold reflects all blocks.
REQ-037 SHALL cover: block end on the same cycle as the out_last transfer -> out_valid stays high, out_chan=0, overrun stays 0.
REQ-038 SHALL cover: block_size changed 4->2 after sample 2 -> current block ends at 4 samples, next at 2; block_size=0 -> every vin ends a block.
REQ-039 SHALL cover: mclk_rst asserted mid-SEND -> out_valid=0 next cycle, next block peak is computed from post-reset samples only.
